// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath widths, writeback select encoding and the
// memory-stage request FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_NPC = 2'd2,
    SRC_LUI = 2'd3
  } write_t;

  typedef enum logic {
    REQ  = 1'b0,
    HELD = 1'b1
  } memstate_t;

endpackage

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory request per instruction, stalls the
// pipeline while it is outstanding, and registers results into MEM/WB.
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     en,
  input  logic     zero,
  input  logic     in_dmemREN,
  input  logic     in_dmemWEN,
  input  logic     in_halt,
  input  word_t    in_alu_result,
  input  word_t    in_dmemstore,
  input  regbits_t in_wsel,
  input  write_t   in_wdat_source,
  input  word_t    in_instr_npc,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     mem_stall,
  output regbits_t fwd_wsel,
  output word_t    fwd_data,
  output logic     out_halt,
  output logic     out_dmemREN,
  output regbits_t out_wsel,
  output write_t   out_wdat_source,
  output word_t    out_alu_result,
  output word_t    out_dmemload,
  output word_t    out_instr_npc
);

  memstate_t state;
  word_t     held_load;
  word_t     load_data;

  assign fwd_wsel  = in_wsel;
  assign fwd_data  = in_alu_result;
  assign dmemaddr  = in_alu_result;
  assign dmemstore = in_dmemstore;
  // A hit that arrived while frozen is replayed from the captured copy.
  assign load_data = (state == HELD) ? held_load : dmemload;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    mem_stall = 1'b0;
    if (state == REQ) begin
      dmemREN   = in_dmemREN;
      dmemWEN   = in_dmemWEN;
      mem_stall = (in_dmemREN | in_dmemWEN) & ~dhit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state           <= REQ;
      held_load       <= '0;
      out_halt        <= 1'b0;
      out_dmemREN     <= 1'b0;
      out_wsel        <= '0;
      out_wdat_source <= SRC_ALU;
      out_alu_result  <= '0;
      out_dmemload    <= '0;
      out_instr_npc   <= '0;
    end else begin
      case (state)
        REQ: begin
          // Cache finished while another hazard froze us: keep the data and
          // stop requesting so a store is never issued twice.
          if (dhit && !en) begin
            state     <= HELD;
            held_load <= dmemload;
          end
        end
        HELD: begin
          if (en) state <= REQ;
        end
        default: state <= REQ;
      endcase

      if (en) begin
        if (zero) begin
          out_halt        <= 1'b0;
          out_dmemREN     <= 1'b0;
          out_wsel        <= '0;
          out_wdat_source <= SRC_ALU;
          out_alu_result  <= '0;
          out_dmemload    <= '0;
          out_instr_npc   <= '0;
        end else begin
          out_halt        <= in_halt;
          out_dmemREN     <= in_dmemREN;
          out_wsel        <= in_wsel;
          out_wdat_source <= in_wdat_source;
          out_alu_result  <= in_alu_result;
          out_dmemload    <= load_data;
          out_instr_npc   <= in_instr_npc;
        end
      end
    end
  end

endmodule
